// File: rtl/uart_rx_fifo.sv
// UART receive front end: 2-FF synchronized, 16x oversampled 8N1 deserializer
// feeding a show-ahead register FIFO that flags framing errors and overruns.
module uart_rx_fifo #(
    parameter int DVSR        = 54,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_uart,
    output logic [7:0] r_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int TW    = $clog2(DVSR);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic rx_meta, rx_s;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    state_t     state, state_n;
    logic [3:0] s, s_n;
    logic [2:0] n, n_n;
    logic [7:0] b, b_n;
    logic       rx_done, stop_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_n  = state;
        s_n      = s;
        n_n      = n;
        b_n      = b;
        rx_done  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        s_n = '0;
                        b_n = {rx_s, b[7:1]};
                        if (n == 3'd7) state_n = STOP;
                        else           n_n     = n + 3'd1;
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        state_n  = IDLE;
                        rx_done  = rx_s;
                        stop_bad = !rx_s;
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_W:0]   count;
    logic                   do_push, do_pop;

    assign rx_empty  = (count == '0);
    assign rx_full   = (count == (FIFO_ADDR_W + 1)'(DEPTH));
    assign do_pop    = rd_uart && !rx_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push   = rx_done && (!rx_full || do_pop);
    assign overrun   = rx_done && rx_full && !do_pop;
    assign frame_err = stop_bad;
    assign r_data    = mem[rd_ptr];

    // NOTE: the storage array has no reset; r_data is only meaningful while rx_empty is low.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: drives 8N1 frames, predicts FIFO contents
// and pulse timing from the tick grid, and compares the DUT every cycle.
module tb_uart_rx_fifo;
    localparam int DVSR  = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_uart = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty, rx_full, frame_err, overrun;

    uart_rx_fifo #(.DVSR(DVSR), .FIFO_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_uart(rd_uart), .r_data(r_data),
        .rx_empty(rx_empty), .rx_full(rx_full), .frame_err(frame_err), .overrun(overrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         ok;
    } pend_t;

    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] q[$];
    logic [7:0] model_popped[$];
    logic [7:0] popped[$];
    pend_t      pend[$];
    int         fe_count = 0;
    int         ov_count = 0;
    int         pop_req = 0;
    bit         auto_rd = 1'b0;
    int         rd_pct = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: cycle index since reset, ticks act on every DVSR-th edge;
    // a frame's outcome lands on the edge computed when it is launched.
    task automatic model_step();
        bit pop, ev;
        if (rst) begin
            q.delete();
            pend.delete();
            cyc = 0;
            return;
        end
        cyc++;
        pop = rd_uart && (q.size() > 0);
        ev  = (pend.size() > 0) && (pend[0].at == cyc);
        if (pop) begin
            model_popped.push_back(q[0]);
            void'(q.pop_front());
        end
        if (ev) begin
            if (pend[0].ok && q.size() < DEPTH) q.push_back(pend[0].data);
            void'(pend.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        bit ev_next, fe_exp, ov_exp;
        @(negedge clk);
        if (!rst) begin
            ev_next = (pend.size() > 0) && (pend[0].at == cyc + 1);
            fe_exp  = ev_next && !pend[0].ok;
            ov_exp  = ev_next && pend[0].ok && (q.size() == DEPTH) && !rd_uart;
            check("rx_empty", 32'(rx_empty), 32'(q.size() == 0));
            check("rx_full", 32'(rx_full), 32'(q.size() == DEPTH));
            if (q.size() > 0) check("r_data", 32'(r_data), 32'(q[0]));
            check("frame_err", 32'(frame_err), 32'(fe_exp));
            check("overrun", 32'(overrun), 32'(ov_exp));
            if (frame_err === 1'b1) fe_count++;
            if (overrun === 1'b1) ov_count++;
        end
    end

    // Pairing-stage reader: sees rx_empty low, pops the following cycle.
    initial forever begin
        bit saw;
        @(negedge clk);
        saw = !rst && !rx_empty && !rd_uart;
        if (!rst && rd_uart && !rx_empty) popped.push_back(r_data);
        @(posedge clk);
        #1;
        if (pop_req > 0) begin
            rd_uart = 1'b1;
            pop_req--;
        end else if (auto_rd && saw && ($urandom_range(1, 100) <= rd_pct)) begin
            rd_uart = 1'b1;
        end else begin
            rd_uart = 1'b0;
        end
    end

    task automatic send_frame(input logic [7:0] data, input bit ok, input int gap);
        pend_t e;
        e.at   = ((cyc + 3) / DVSR + 1) * DVSR + 151 * DVSR;
        e.data = data;
        e.ok   = ok;
        pend.push_back(e);
        rx = 1'b0;
        wait_cycles(16 * DVSR);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_cycles(16 * DVSR);
        end
        if (ok) begin
            rx = 1'b1;
            wait_cycles(16 * DVSR);
        end else begin
            rx = 1'b0;
            wait_cycles(10 * DVSR);
            rx = 1'b1;
            wait_cycles(22 * DVSR);
        end
        wait_cycles(gap);
    endtask

    initial begin
        int         mark, fe0, ov0;
        logic [7:0] exp_fill[4];
        logic [7:0] exp_str[3];
        logic [7:0] d;
        exp_fill = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_str  = '{8'h34, 8'h32, 8'h46};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rx_empty", 32'(rx_empty), 32'd1);
        check("reset rx_full", 32'(rx_full), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(20);

        // Single byte, then pop, then pops against an empty FIFO.
        send_frame(8'hA5, 1'b1, 0);
        wait_cycles(2);
        check("single not empty", 32'(rx_empty), 32'd0);
        check("single data", 32'(r_data), 32'hA5);
        pop_req = 1;
        wait_cycles(3);
        check("single drained", 32'(rx_empty), 32'd1);
        pop_req = 2;
        wait_cycles(4);

        // Short low glitch on the line must not produce a byte.
        fe0 = fe_count;
        rx = 1'b0;
        wait_cycles(12);
        rx = 1'b1;
        wait_cycles(40 * DVSR);
        check("glitch frame_err", 32'(fe_count), 32'(fe0));
        check("glitch empty", 32'(rx_empty), 32'd1);

        // Framing error.
        send_frame(8'h3C, 1'b0, 0);
        check("ferr pulses", 32'(fe_count), 32'(fe0 + 1));
        check("ferr empty", 32'(rx_empty), 32'd1);

        // Fill, overrun on the fifth byte, ordered readback.
        ov0 = ov_count;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 0);
            if (i == 4) check("fill full", 32'(rx_full), 32'd1);
        end
        check("overrun pulses", 32'(ov_count), 32'(ov0 + 1));
        mark = popped.size();
        pop_req = 4;
        wait_cycles(8);
        check("fill pop count", 32'(popped.size() - mark), 32'd4);
        for (int i = 0; i < 4; i++)
            if (mark + i < popped.size()) check("fill order", 32'(popped[mark + i]), 32'(exp_fill[i]));

        // Back-to-back stream drained by the pairing stage.
        ov0 = ov_count;
        mark = popped.size();
        auto_rd = 1'b1;
        rd_pct = 100;
        for (int i = 0; i < 3; i++) send_frame(exp_str[i], 1'b1, 0);
        wait_cycles(10);
        check("stream pop count", 32'(popped.size() - mark), 32'd3);
        for (int i = 0; i < 3; i++)
            if (mark + i < popped.size()) check("stream order", 32'(popped[mark + i]), 32'(exp_str[i]));
        check("stream no overrun", 32'(ov_count), 32'(ov0));
        auto_rd = 1'b0;

        // Reset during the data bits of 0x55, then a clean 0x81.
        d = 8'h55;
        rx = 1'b0;
        wait_cycles(16 * DVSR);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_cycles(16 * DVSR);
        end
        rx = d[3];
        wait_cycles(8 * DVSR);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        rx = 1'b1;
        wait_cycles(32 * DVSR);
        send_frame(8'h81, 1'b1, 0);
        wait_cycles(2);
        check("post-reset data", 32'(r_data), 32'h81);
        check("post-reset not empty", 32'(rx_empty), 32'd0);
        pop_req = 1;
        wait_cycles(3);
        check("post-reset single", 32'(rx_empty), 32'd1);

        // Randomized frames with a randomly stalling reader.
        for (int k = 0; k < 16; k++) begin
            auto_rd = ($urandom_range(0, 2) != 0);
            rd_pct  = $urandom_range(20, 100);
            send_frame(8'($urandom), ($urandom_range(0, 9) != 0), $urandom_range(0, 3 * DVSR));
        end
        auto_rd = 1'b1;
        rd_pct = 100;
        wait_cycles(20);
        check("final empty", 32'(rx_empty), 32'd1);
        check("popped count", 32'(popped.size()), 32'(model_popped.size()));
        for (int i = 0; i < popped.size() && i < model_popped.size(); i++)
            check("popped order", 32'(popped[i]), 32'(model_popped[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
